tap_ctrl: RTL and testbench
===========================

TAP_CTRL -- requirements
Module: tap_ctrl

Interface
REQ-001 Parameter IR_WIDTH, default 4: instruction register width; SHALL be at least 2.
REQ-002 Parameter IDCODE_VAL, default 32'h1000_0001: 32-bit device ID; bit0 SHALL be 1.
REQ-003 Parameter IDCODE_INSTR, default 4'b0001 (IR_WIDTH bits): opcode that selects the IDCODE register.
REQ-004 Parameter USER_INSTR, default 4'b1000 (IR_WIDTH bits): opcode that selects the user DR.
REQ-005 Parameter USER_WIDTH, default 8: user DR width; SHALL be at least 1.
REQ-006 Port TCK, input, 1: the single clock; every register SHALL update on the rising edge.
REQ-007 Port TRST_N, input, 1: reset, synchronous and active-low.
REQ-008 Port TMS, input, 1: test mode select.
REQ-009 Port TDI, input, 1: serial data in.
REQ-010 Port TDO, output, 1: serial data out.
REQ-011 Port TDO_EN, output, 1: high only in Shift_DR or Shift_IR.
REQ-012 Port state_obs, output, 4: current state code.
REQ-013 Port ir_out, output, IR_WIDTH: the latched instruction.
REQ-014 Port user_dr_out, output, USER_WIDTH: the latched user DR value.
REQ-015 Port user_capture, output, 1: one-cycle strobe.
REQ-016 Port user_update, output, 1: one-cycle strobe.
REQ-017 Port user_dr_in, input, USER_WIDTH: parallel value captured into the user DR.

Function
REQ-018 The FSM SHALL implement the 16 IEEE 1149.1 states with these fixed codes: TLR=0, RTI=1, SelDR=2, CapDR=3, ShDR=4, Ex1DR=5, PauDR=6, Ex2DR=7, UpdDR=8, SelIR=9, CapIR=10, ShIR=11, Ex1IR=12, PauIR=13, Ex2IR=14, UpdIR=15.
REQ-019 Transitions SHALL follow the standard TMS graph; TMS=1 for 5 consecutive TCK edges SHALL reach TLR from any state.
REQ-020 state_obs SHALL equal the state register directly, with no extra cycle of delay.
REQ-021 While in TLR, ir_out SHALL be loaded with IDCODE_INSTR every cycle.
REQ-022 Active DR select SHALL come from ir_out: IDCODE_INSTR selects the 32-bit ID register; USER_INSTR selects the USER_WIDTH user shift register; all-ones and every other code select the 1-bit bypass register.
REQ-023 Edge in CapIR: the IR shift register SHALL load {0..0,2'b01}.
REQ-024 Edge in CapDR: the selected DR SHALL load as follows:
- ID register: IDCODE_VAL.
- Bypass register: 0.
- User register: user_dr_in.
REQ-025 Edge in ShIR or ShDR: the selected shift register SHALL become {TDI, reg[MSB:1]} (LSB-first).
REQ-026 TDO SHALL be combinational: the selected register bit0 in a Shift state, otherwise 0.
REQ-027 Edge in UpdIR: ir_out SHALL load the IR shift register.
REQ-028 Edge in UpdDR with USER selected: user_dr_out SHALL load the user shift register.
REQ-029 Shift registers SHALL hold their value in Exit and Pause states, so a shift resumes after Ex2->Sh without data loss.
REQ-030 user_capture SHALL be high in exactly the cycle the FSM is in CapDR with USER selected.
REQ-031 user_update SHALL be high in exactly the cycle the FSM is in UpdDR with USER selected.
REQ-032 In every other state and with every other instruction, user_capture and user_update SHALL be 0.
REQ-033 The 0/1 loop states (TLR, RTI, ShDR, PauDR, ShIR, PauIR) SHALL hold state on their self-loop TMS value.
REQ-034 Unreachable codes SHALL NOT exist; all 16 codes are legal.

Reset
REQ-035 When TRST_N=0 at a TCK edge, the block SHALL load:
- state = TLR.
- ir_out = IDCODE_INSTR.
- IR, ID, bypass and user shift registers = 0.
- user_dr_out = 0.
REQ-036 Reset SHALL override TMS and any shift in progress.
REQ-037 Outputs after reset SHALL be: state_obs=0, TDO=0, TDO_EN=0, user_capture=0, user_update=0.
REQ-038 Reset mid-operation (for example in ShDR) SHALL discard the partial shift; user_dr_out SHALL become 0 on that edge.

Verification
REQ-039 Reset-from-anywhere: drive any state, then TMS=1 for 5 edges -> state_obs=0; ir_out=IDCODE_INSTR.
REQ-040 IDCODE read: after reset, TMS 0,1,0,0 -> ShDR; 32 shifts -> TDO yields 32'h1000_0001 LSB-first; TDO_EN=1 throughout.
REQ-041 IR scan: in ShIR, first 2 TDO bits = 1,0; shift in 4'b1000 and pass UpdIR -> ir_out=4'b1000.
REQ-042 Bypass: ir_out=4'b1111; shift TDI pattern 1,0,1,1 -> TDO = 0,1,0,1 (one-bit delay).
REQ-043 User DR write:
- Stimulus: USER selected, user_dr_in=8'h3C; pass CapDR; shift in 8'hA5 with Ex1/Pau/Ex2 in the middle; pass UpdDR.
- Response: user_capture pulses once; TDO emits 8'h3C LSB-first; user_dr_out=8'hA5 with user_update high for 1 cycle.
REQ-044 Mid-shift reset: TRST_N=0 during ShDR -> next cycle state_obs=0, user_dr_out=0, TDO_EN=0.

Source files
------------

// File: rtl/tap_ctrl.sv
// IEEE 1149.1 TAP controller with IR, IDCODE, bypass and a parallel-access user DR.
// The 16-state FSM code is visible on state_obs; the user DR is strobed out via user_capture/user_update.
module tap_ctrl #(
  parameter int                  IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VAL   = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = IR_WIDTH'(4'b0001),
  parameter logic [IR_WIDTH-1:0] USER_INSTR   = IR_WIDTH'(4'b1000),
  parameter int                  USER_WIDTH   = 8
) (
  input  logic                  TCK,
  input  logic                  TRST_N,
  input  logic                  TMS,
  input  logic                  TDI,
  output logic                  TDO,
  output logic                  TDO_EN,
  output logic [3:0]            state_obs,
  output logic [IR_WIDTH-1:0]   ir_out,
  output logic [USER_WIDTH-1:0] user_dr_out,
  output logic                  user_capture,
  output logic                  user_update,
  input  logic [USER_WIDTH-1:0] user_dr_in
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } state_t;

  state_t                  state, state_nxt;
  logic [IR_WIDTH-1:0]     ir_sr;
  logic [31:0]             id_sr;
  logic                    byp_sr;
  logic [USER_WIDTH-1:0]   user_sr;
  logic                    sel_id, sel_user;

  always_ff @(posedge TCK) begin
    if (!TRST_N) state <= TLR;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TLR:    state_nxt = TMS ? TLR    : RTI;
      RTI:    state_nxt = TMS ? SEL_DR : RTI;
      SEL_DR: state_nxt = TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_nxt = TMS ? EX1_DR : SH_DR;
      SH_DR:  state_nxt = TMS ? EX1_DR : SH_DR;
      EX1_DR: state_nxt = TMS ? UPD_DR : PAU_DR;
      PAU_DR: state_nxt = TMS ? EX2_DR : PAU_DR;
      EX2_DR: state_nxt = TMS ? UPD_DR : SH_DR;
      UPD_DR: state_nxt = TMS ? SEL_DR : RTI;
      SEL_IR: state_nxt = TMS ? TLR    : CAP_IR;
      CAP_IR: state_nxt = TMS ? EX1_IR : SH_IR;
      SH_IR:  state_nxt = TMS ? EX1_IR : SH_IR;
      EX1_IR: state_nxt = TMS ? UPD_IR : PAU_IR;
      PAU_IR: state_nxt = TMS ? EX2_IR : PAU_IR;
      EX2_IR: state_nxt = TMS ? UPD_IR : SH_IR;
      UPD_IR: state_nxt = TMS ? SEL_DR : RTI;
      default: state_nxt = TLR;
    endcase
  end

  // IDCODE wins if both opcodes were configured identical; anything else is bypass.
  assign sel_id   = (ir_out == IDCODE_INSTR);
  assign sel_user = (ir_out == USER_INSTR) && !sel_id;

  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      ir_out      <= IDCODE_INSTR;
      ir_sr       <= '0;
      id_sr       <= '0;
      byp_sr      <= 1'b0;
      user_sr     <= '0;
      user_dr_out <= '0;
    end else begin
      case (state)
        TLR:    ir_out <= IDCODE_INSTR;
        CAP_IR: ir_sr  <= IR_WIDTH'(2'b01);
        SH_IR:  ir_sr  <= (ir_sr >> 1) | (IR_WIDTH'(TDI) << (IR_WIDTH - 1));
        UPD_IR: ir_out <= ir_sr;
        CAP_DR: begin
          if (sel_id)        id_sr   <= IDCODE_VAL;
          else if (sel_user) user_sr <= user_dr_in;
          else               byp_sr  <= 1'b0;
        end
        SH_DR: begin
          // Shifts use >> so a 1-bit user DR needs no special case.
          if (sel_id)        id_sr   <= {TDI, id_sr[31:1]};
          else if (sel_user) user_sr <= (user_sr >> 1) | (USER_WIDTH'(TDI) << (USER_WIDTH - 1));
          else               byp_sr  <= TDI;
        end
        UPD_DR: if (sel_user) user_dr_out <= user_sr;
        default: ;
      endcase
    end
  end

  always_comb begin
    TDO = 1'b0;
    case (state)
      SH_IR: TDO = ir_sr[0];
      SH_DR: TDO = sel_id ? id_sr[0] : (sel_user ? user_sr[0] : byp_sr);
      default: TDO = 1'b0;
    endcase
  end

  assign TDO_EN       = (state == SH_DR) || (state == SH_IR);
  assign state_obs    = state;
  assign user_capture = (state == CAP_DR) && sel_user;
  assign user_update  = (state == UPD_DR) && sel_user;

endmodule

// File: tb/tb_tap_ctrl.sv
// Bench for tap_ctrl: directed scans plus random TMS walks, every cycle compared
// against a table-driven TAP model kept in this file.
module tb_tap_ctrl;
  localparam logic [3:0]  IDI = 4'b0001;
  localparam logic [3:0]  USI = 4'b1000;
  localparam logic [31:0] IDV = 32'h1000_0001;

  logic       TCK, TRST_N, TMS, TDI, TDO, TDO_EN;
  logic [3:0] state_obs, ir_out;
  logic [7:0] user_dr_out, user_dr_in;
  logic       user_capture, user_update;

  tap_ctrl #(.IR_WIDTH(4), .IDCODE_VAL(IDV), .IDCODE_INSTR(IDI),
             .USER_INSTR(USI), .USER_WIDTH(8)) dut (
    .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .state_obs(state_obs), .ir_out(ir_out), .user_dr_out(user_dr_out),
    .user_capture(user_capture), .user_update(user_update), .user_dr_in(user_dr_in)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  int n_pass = 0;
  int n_total = 0;
  int nxt0 [16];
  int nxt1 [16];
  int m_state;
  logic [3:0]  m_ir, m_irsr;
  logic [31:0] m_id;
  logic        m_byp;
  logic [7:0]  m_usr, m_udo;
  logic        last_tdo;
  int          cap_cnt, upd_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // 0 = ID register, 1 = user register, 2 = bypass
  function automatic int m_sel();
    if (m_ir == IDI) return 0;
    if (m_ir == USI) return 1;
    return 2;
  endfunction

  function automatic logic m_tdo();
    if (m_state == 11) return m_irsr[0];
    if (m_state == 4) begin
      if (m_sel() == 0) return m_id[0];
      if (m_sel() == 1) return m_usr[0];
      return m_byp;
    end
    return 1'b0;
  endfunction

  task automatic model_edge(input logic tms_v, input logic tdi_v, input logic rst_n_v);
    if (!rst_n_v) begin
      m_state = 0; m_ir = IDI; m_irsr = 0; m_id = 0; m_byp = 0; m_usr = 0; m_udo = 0;
      return;
    end
    case (m_state)
      0:  m_ir = IDI;
      10: m_irsr = 4'd1;
      11: m_irsr = (m_irsr >> 1) | (tdi_v ? 4'b1000 : 4'b0000);
      15: m_ir = m_irsr;
      3: begin
        if (m_sel() == 0)      m_id  = IDV;
        else if (m_sel() == 1) m_usr = user_dr_in;
        else                   m_byp = 1'b0;
      end
      4: begin
        if (m_sel() == 0)      m_id  = (m_id >> 1) | (tdi_v ? 32'h8000_0000 : 32'h0);
        else if (m_sel() == 1) m_usr = (m_usr >> 1) | (tdi_v ? 8'h80 : 8'h00);
        else                   m_byp = tdi_v;
      end
      8: if (m_sel() == 1) m_udo = m_usr;
      default: ;
    endcase
    m_state = tms_v ? nxt1[m_state] : nxt0[m_state];
  endtask

  task automatic stepx(input logic tms_v, input logic tdi_v, input logic rst_n_v, input logic chk);
    TMS = tms_v; TDI = tdi_v; TRST_N = rst_n_v;
    #1;
    if (chk) begin
      check("state_obs",    32'(state_obs),    32'(m_state));
      check("tdo",          32'(TDO),          32'(m_tdo()));
      check("tdo_en",       32'(TDO_EN),       32'(m_state == 4 || m_state == 11));
      check("ir_out",       32'(ir_out),       32'(m_ir));
      check("user_dr_out",  32'(user_dr_out),  32'(m_udo));
      check("user_capture", 32'(user_capture), 32'(m_state == 3 && m_sel() == 1));
      check("user_update",  32'(user_update),  32'(m_state == 8 && m_sel() == 1));
      cap_cnt += int'(user_capture);
      upd_cnt += int'(user_update);
    end
    last_tdo = TDO;
    @(posedge TCK);
    model_edge(tms_v, tdi_v, rst_n_v);
    #1;
  endtask

  task automatic step(input logic tms_v, input logic tdi_v);
    stepx(tms_v, tdi_v, 1'b1, 1'b1);
  endtask

  // From RTI: load an instruction through the IR path and return to RTI.
  task automatic ir_scan(input logic [3:0] v, output logic [3:0] tdo_bits);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, v[i]);
      tdo_bits[i] = last_tdo;
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] id_bits;
    logic [3:0]  b4, bp, bo;
    logic [7:0]  wv, ub;
    logic        r;
    nxt0 = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    nxt1 = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    cap_cnt = 0; upd_cnt = 0;
    user_dr_in = 8'h00; TMS = 1'b1; TDI = 1'b0; TRST_N = 1'b0;

    // Reset: state of the DUT is unknown before the first edge.
    stepx(1'b0, 1'b1, 1'b0, 1'b0);
    check("rst_state_obs", 32'(state_obs), 32'h0);
    check("rst_ir_out", 32'(ir_out), 32'(IDI));
    check("rst_tdo_en", 32'(TDO_EN), 32'h0);
    stepx(1'b1, 1'b0, 1'b0, 1'b1);

    // IDCODE read
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      check("idcode_tdo_en", 32'(TDO_EN), 32'h1);
      r = 1'($urandom);
      step(i == 31, r);
      id_bits[i] = last_tdo;
    end
    check("idcode_value", id_bits, 32'h1000_0001);
    step(1'b1, 1'b0); step(1'b0, 1'b0);

    // IR scan selecting USER
    ir_scan(USI, b4);
    check("ir_cap_bit0", 32'(b4[0]), 32'h1);
    check("ir_cap_bit1", 32'(b4[1]), 32'h0);
    check("ir_user_loaded", 32'(ir_out), 32'h8);

    // User DR write with a pause in the middle of the shift
    user_dr_in = 8'h3C; wv = 8'hA5; cap_cnt = 0; upd_cnt = 0;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    user_dr_in = 8'hFF;
    for (int i = 0; i < 4; i++) begin step(i == 3, wv[i]); ub[i] = last_tdo; end
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    for (int i = 4; i < 8; i++) begin step(i == 7, wv[i]); ub[i] = last_tdo; end
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    check("user_tdo_capture", 32'(ub), 32'h3C);
    check("user_dr_out_a5", 32'(user_dr_out), 32'hA5);
    check("user_capture_pulses", 32'(cap_cnt), 32'h1);
    check("user_update_pulses", 32'(upd_cnt), 32'h1);

    // Reset in the middle of a user DR shift
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b0);
    stepx(1'b0, 1'b1, 1'b0, 1'b1);
    check("midrst_state_obs", 32'(state_obs), 32'h0);
    check("midrst_user_dr_out", 32'(user_dr_out), 32'h0);
    check("midrst_tdo_en", 32'(TDO_EN), 32'h0);
    check("midrst_tdo", 32'(TDO), 32'h0);
    check("midrst_ir_out", 32'(ir_out), 32'(IDI));

    // Bypass: one-bit delay
    step(1'b0, 1'b0);
    ir_scan(4'b1111, b4);
    check("ir_bypass_loaded", 32'(ir_out), 32'hF);
    bp = 4'b1101;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin step(i == 3, bp[i]); bo[i] = last_tdo; end
    check("bypass_tdo", 32'(bo), 32'hA);
    step(1'b1, 1'b0); step(1'b0, 1'b0);

    // Five TMS=1 edges reach TLR from wherever a random walk ended
    for (int k = 0; k < 16; k++) begin
      int n;
      n = int'($urandom_range(1, 24));
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 7) == 0) user_dr_in = 8'($urandom);
        step(1'($urandom), 1'($urandom));
      end
      for (int j = 0; j < 5; j++) step(1'b1, 1'($urandom));
      check("tlr_after_5", 32'(state_obs), 32'h0);
      step(1'b1, 1'b0);
      check("tlr_ir_idcode", 32'(ir_out), 32'(IDI));
    end

    // Long random walk with occasional resets and new parallel inputs
    for (int j = 0; j < 600; j++) begin
      if ($urandom_range(0, 5) == 0) user_dr_in = 8'($urandom);
      stepx(1'($urandom), 1'($urandom), ($urandom_range(0, 60) != 0), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
